// File: rtl/itch_pkg.sv
// itch_pkg: shared definitions for the ITCH serializer and its companion parser.
// Holds the message type codes, per-type frame lengths, the field bundle that
// both directions exchange, and small helpers for type classification.
package itch_pkg;

  localparam logic [7:0] MSG_A = 8'h41;  // add order
  localparam logic [7:0] MSG_E = 8'h45;  // order executed
  localparam logic [7:0] MSG_X = 8'h58;  // order cancel
  localparam logic [7:0] MSG_D = 8'h44;  // order delete

  localparam logic [5:0] LEN_A = 6'd36;
  localparam logic [5:0] LEN_E = 6'd31;
  localparam logic [5:0] LEN_X = 6'd23;
  localparam logic [5:0] LEN_D = 6'd19;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } itch_state_t;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] stock_locate;
    logic [15:0] tracking_no;
    logic [47:0] timestamp;
    logic [63:0] order_ref_no;
    logic [31:0] shares;
    logic [7:0]  buy_sell;
    logic [63:0] stock;
    logic [31:0] price;
    logic [63:0] match_no;
  } itch_fields_t;

  // Frame length in bytes; zero marks an unsupported type.
  function automatic logic [5:0] msg_len(input logic [7:0] msg_type);
    logic [5:0] len;
    case (msg_type)
      MSG_A:   len = LEN_A;
      MSG_E:   len = LEN_E;
      MSG_X:   len = LEN_X;
      MSG_D:   len = LEN_D;
      default: len = 6'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_known(input logic [7:0] msg_type);
    return msg_len(msg_type) != 6'd0;
  endfunction

endpackage

// File: rtl/itch_serializer.sv
// itch_serializer: turns one parallel ITCH field set into a gap-free stream of
// big-endian bytes. One message is in flight (active) while one more may wait
// (pending), so consecutive messages follow with zero idle cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load / ready      field-set handshake; accepted when load && ready
//   in_*              message type and field values to transmit
//   message, valid    serial byte and its qualifier (message is 0 when idle)
//   start_msg/end_msg first/last byte markers, qualified by valid
//   err               one-cycle pulse after an accepted unknown type
//   sent_count        completed messages, wraps at 16 bits
module itch_serializer
  import itch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  output logic        ready,
  input  logic [7:0]  in_msg_type,
  input  logic [15:0] in_stock_locate,
  input  logic [15:0] in_tracking_no,
  input  logic [47:0] in_timestamp,
  input  logic [63:0] in_order_ref_no,
  input  logic [31:0] in_shares,
  input  logic [7:0]  in_buy_sell,
  input  logic [63:0] in_stock,
  input  logic [31:0] in_price,
  input  logic [63:0] in_match_no,
  output logic [7:0]  message,
  output logic        valid,
  output logic        start_msg,
  output logic        end_msg,
  output logic        err,
  output logic [15:0] sent_count
);

  itch_state_t  state_reg, state_next;
  logic [5:0]   byte_idx_reg, byte_idx_next;
  itch_fields_t active_reg, active_next;
  itch_fields_t pending_reg, pending_next;
  logic         pending_full_reg, pending_full_next;
  logic         err_reg, err_next;
  logic [15:0]  sent_count_reg, sent_count_next;

  itch_fields_t in_fields;
  logic         accept;
  logic         in_known;
  logic         last_byte;
  logic [135:0] tail;
  logic [287:0] frame;
  logic [287:0] frame_shifted;

  always_comb begin
    in_fields              = '0;
    in_fields.msg_type     = in_msg_type;
    in_fields.stock_locate = in_stock_locate;
    in_fields.tracking_no  = in_tracking_no;
    in_fields.timestamp    = in_timestamp;
    in_fields.order_ref_no = in_order_ref_no;
    in_fields.shares       = in_shares;
    in_fields.buy_sell     = in_buy_sell;
    in_fields.stock        = in_stock;
    in_fields.price        = in_price;
    in_fields.match_no     = in_match_no;
  end

  assign ready     = !pending_full_reg;
  assign accept    = load && ready;
  assign in_known  = is_known(in_msg_type);
  assign last_byte = (state_reg == SEND) &&
                     (byte_idx_reg == msg_len(active_reg.msg_type) - 6'd1);

  // Next-state logic. Unknown types are dropped at the handshake so they never
  // reach the active or pending buffers; only err reflects them.
  always_comb begin
    state_next        = state_reg;
    byte_idx_next     = byte_idx_reg;
    active_next       = active_reg;
    pending_next      = pending_reg;
    pending_full_next = pending_full_reg;
    sent_count_next   = sent_count_reg;
    err_next          = accept && !in_known;

    case (state_reg)
      IDLE: begin
        byte_idx_next = 6'd0;
        if (accept && in_known) begin
          active_next = in_fields;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (last_byte) begin
          sent_count_next = sent_count_reg + 16'd1;
          byte_idx_next   = 6'd0;
          if (pending_full_reg) begin
            // Waiting message takes over without a gap.
            active_next       = pending_reg;
            pending_next      = '0;
            pending_full_next = 1'b0;
          end else if (accept && in_known) begin
            // A load arriving on the final byte bypasses the pending buffer.
            active_next = in_fields;
          end else begin
            state_next = IDLE;
          end
        end else begin
          byte_idx_next = byte_idx_reg + 6'd1;
          if (accept && in_known) begin
            pending_next      = in_fields;
            pending_full_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      byte_idx_reg     <= 6'd0;
      active_reg       <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      err_reg          <= 1'b0;
      sent_count_reg   <= 16'd0;
    end else begin
      state_reg        <= state_next;
      byte_idx_reg     <= byte_idx_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      pending_full_reg <= pending_full_next;
      err_reg          <= err_next;
      sent_count_reg   <= sent_count_next;
    end
  end

  // Byte selection: the 19-byte common header followed by a type-specific
  // tail, left-aligned in a 36-byte frame and shifted by the byte index.
  always_comb begin
    tail = '0;
    case (active_reg.msg_type)
      MSG_A:   tail = {active_reg.buy_sell, active_reg.shares,
                       active_reg.stock, active_reg.price};
      MSG_E:   tail = {active_reg.shares, active_reg.match_no, 40'd0};
      MSG_X:   tail = {active_reg.shares, 104'd0};
      default: tail = '0;
    endcase
    frame = {active_reg.msg_type, active_reg.stock_locate, active_reg.tracking_no,
             active_reg.timestamp, active_reg.order_ref_no, tail};
    frame_shifted = frame << {byte_idx_reg, 3'b000};
  end

  assign valid      = (state_reg == SEND);
  assign message    = valid ? frame_shifted[287:280] : 8'h00;
  assign start_msg  = valid && (byte_idx_reg == 6'd0);
  assign end_msg    = last_byte;
  assign err        = err_reg;
  assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_itch_serializer.sv
// Self-checking bench for itch_serializer: directed scenarios with randomized
// field values, then a long randomized run against a cycle-accurate
// reference built from message lengths and arrival times, with a byte-level
// parser that decodes every emitted frame back into fields.
module tb_itch_serializer;
  import itch_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst;
  logic        load;
  logic        ready;
  logic [7:0]  in_msg_type;
  logic [15:0] in_stock_locate;
  logic [15:0] in_tracking_no;
  logic [47:0] in_timestamp;
  logic [63:0] in_order_ref_no;
  logic [31:0] in_shares;
  logic [7:0]  in_buy_sell;
  logic [63:0] in_stock;
  logic [31:0] in_price;
  logic [63:0] in_match_no;
  logic [7:0]  message;
  logic        valid;
  logic        start_msg;
  logic        end_msg;
  logic        err;
  logic [15:0] sent_count;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  byte_q_t frame_q;
  byte_q_t exp_q;
  byte_q_t rx_q;
  int      rx_pos;

  localparam int NC = 1500;
  int exp_b [0:NC+99];
  bit exp_s [0:NC+99];
  bit exp_e [0:NC+99];
  bit exp_err [0:NC+99];

  itch_serializer dut (
    .clk(clk), .rst(rst), .load(load), .ready(ready),
    .in_msg_type(in_msg_type), .in_stock_locate(in_stock_locate),
    .in_tracking_no(in_tracking_no), .in_timestamp(in_timestamp),
    .in_order_ref_no(in_order_ref_no), .in_shares(in_shares),
    .in_buy_sell(in_buy_sell), .in_stock(in_stock), .in_price(in_price),
    .in_match_no(in_match_no), .message(message), .valid(valid),
    .start_msg(start_msg), .end_msg(end_msg), .err(err), .sent_count(sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic itch_fields_t rand_fields(input logic [7:0] t);
    itch_fields_t f;
    logic [31:0] r;
    logic [63:0] w;
    f = '0;
    f.msg_type = t;
    r = $urandom; f.stock_locate = r[15:0]; f.tracking_no = r[31:16];
    w = {$urandom, $urandom}; f.timestamp = w[47:0];
    f.order_ref_no = {$urandom, $urandom};
    f.shares = $urandom;
    r = $urandom; f.buy_sell = r[7:0];
    f.stock = {$urandom, $urandom};
    f.price = $urandom;
    f.match_no = {$urandom, $urandom};
    return f;
  endfunction

  task automatic set_fields(input itch_fields_t f);
    in_msg_type = f.msg_type;
    in_stock_locate = f.stock_locate;
    in_tracking_no = f.tracking_no;
    in_timestamp = f.timestamp;
    in_order_ref_no = f.order_ref_no;
    in_shares = f.shares;
    in_buy_sell = f.buy_sell;
    in_stock = f.stock;
    in_price = f.price;
    in_match_no = f.match_no;
  endtask

  task automatic add_bytes(input logic [63:0] v, input int nb);
    for (int b = nb - 1; b >= 0; b--) frame_q.push_back(v[8*b +: 8]);
  endtask

  // Reference frame straight from the field layout table.
  task automatic build_frame(input itch_fields_t f);
    frame_q.delete();
    add_bytes({56'd0, f.msg_type}, 1);
    add_bytes({48'd0, f.stock_locate}, 2);
    add_bytes({48'd0, f.tracking_no}, 2);
    add_bytes({16'd0, f.timestamp}, 6);
    add_bytes(f.order_ref_no, 8);
    if (f.msg_type == 8'h58 || f.msg_type == 8'h45) add_bytes({32'd0, f.shares}, 4);
    if (f.msg_type == 8'h45) add_bytes(f.match_no, 8);
    if (f.msg_type == 8'h41) begin
      add_bytes({56'd0, f.buy_sell}, 1);
      add_bytes({32'd0, f.shares}, 4);
      add_bytes(f.stock, 8);
      add_bytes({32'd0, f.price}, 4);
    end
  endtask

  task automatic take(input int nb, output logic [63:0] v);
    v = '0;
    for (int k = 0; k < nb; k++) begin
      v = {v[55:0], (rx_pos < rx_q.size()) ? rx_q[rx_pos] : 8'h00};
      rx_pos++;
    end
  endtask

  // Loopback parser: decode a received frame into the field bundle.
  task automatic parse_rx(output itch_fields_t d);
    logic [63:0] v;
    d = '0;
    rx_pos = 0;
    take(1, v); d.msg_type = v[7:0];
    take(2, v); d.stock_locate = v[15:0];
    take(2, v); d.tracking_no = v[15:0];
    take(6, v); d.timestamp = v[47:0];
    take(8, v); d.order_ref_no = v;
    if (d.msg_type == 8'h41) begin
      take(1, v); d.buy_sell = v[7:0];
      take(4, v); d.shares = v[31:0];
      take(8, v); d.stock = v;
      take(4, v); d.price = v[31:0];
    end else if (d.msg_type == 8'h45) begin
      take(4, v); d.shares = v[31:0];
      take(8, v); d.match_no = v;
    end else if (d.msg_type == 8'h58) begin
      take(4, v); d.shares = v[31:0];
    end
  endtask

  function automatic itch_fields_t carried(input itch_fields_t f);
    itch_fields_t m;
    m = f;
    if (f.msg_type != 8'h41) begin m.buy_sell = '0; m.stock = '0; m.price = '0; end
    if (f.msg_type != 8'h45) m.match_no = '0;
    if (f.msg_type == 8'h44) m.shares = '0;
    return m;
  endfunction

  task automatic test_reset;
    rst = 1'b1; load = 1'b0;
    set_fields('0);
    repeat (3) tick();
    total++;
    if ({valid, message, start_msg, end_msg, err} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b m=%h s=%b e=%b err=%b, want all zero",
               valid, message, start_msg, end_msg, err);
    end
    total++;
    if (sent_count !== 16'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", sent_count);
    end
    rst = 1'b0;
    tick();
    total++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", ready, valid);
    end
    exp_count = 0;
  endtask

  task automatic test_single_d;
    itch_fields_t f;
    int n;
    tick();
    f = rand_fields(MSG_D);
    f.stock_locate = 16'h0102;
    f.order_ref_no = 64'h1122334455667788;
    build_frame(f);
    n = frame_q.size();
    set_fields(f); load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if ({valid, message, start_msg, end_msg} !== {1'b1, frame_q[i], i == 0, i == n - 1}) begin
        bad++;
        $display("FAIL single_d byte %0d: got v=%b m=%h s=%b e=%b want v=1 m=%h s=%b e=%b",
                 i, valid, message, start_msg, end_msg, frame_q[i], i == 0, i == n - 1);
      end
    end
    @(negedge clk);
    exp_count++;
    total++;
    if (valid !== 1'b0 || sent_count !== exp_count[15:0]) begin
      bad++;
      $display("FAIL single_d_after: got valid=%b count=%0d want 0/%0d", valid, sent_count, exp_count);
    end
  endtask

  // Runs two messages where the second load is issued at cycle load_at
  // (counted from the first message's byte 0) and checks the joined stream.
  task automatic two_messages(input string name, input logic [7:0] t1, input logic [7:0] t2,
                              input int load_at);
    itch_fields_t f1, f2;
    int n1, n;
    bit pend;
    tick();
    f1 = rand_fields(t1);
    f2 = rand_fields(t2);
    build_frame(f1);
    exp_q = frame_q;
    n1 = frame_q.size();
    build_frame(f2);
    foreach (frame_q[k]) exp_q.push_back(frame_q[k]);
    n = exp_q.size();
    pend = (load_at < n1 - 1);
    set_fields(f1); load = 1'b1;
    tick();
    for (int c = 0; c < n; c++) begin
      if (c == load_at) begin set_fields(f2); load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
      total++;
      if ({valid, message, start_msg, end_msg} !==
          {1'b1, exp_q[c], c == 0 || c == n1, c == n1 - 1 || c == n - 1}) begin
        bad++;
        $display("FAIL %s byte %0d: got v=%b m=%h s=%b e=%b want v=1 m=%h s=%b e=%b", name, c,
                 valid, message, start_msg, end_msg, exp_q[c], c == 0 || c == n1,
                 c == n1 - 1 || c == n - 1);
      end
      total++;
      if (ready !== !(pend && c > load_at && c < n1)) begin
        bad++;
        $display("FAIL %s ready at %0d: got %b want %b", name, c, ready,
                 !(pend && c > load_at && c < n1));
      end
      total++;
      if (sent_count !== 16'(exp_count + ((c >= n1) ? 1 : 0))) begin
        bad++;
        $display("FAIL %s count at %0d: got %0d want %0d", name, c, sent_count,
                 exp_count + ((c >= n1) ? 1 : 0));
      end
      tick();
    end
    load = 1'b0;
    @(negedge clk);
    exp_count += 2;
    total++;
    if (valid !== 1'b0 || sent_count !== exp_count[15:0]) begin
      bad++;
      $display("FAIL %s_after: got valid=%b count=%0d want 0/%0d", name, valid, sent_count, exp_count);
    end
  endtask

  task automatic test_back_to_back;
    two_messages("back_to_back_A_E", MSG_A, MSG_E, 5);
  endtask

  task automatic test_load_on_end;
    two_messages("load_on_end_X_D", MSG_X, MSG_D, 22);
  endtask

  task automatic test_unknown;
    itch_fields_t f;
    tick();
    f = rand_fields(8'h5A);
    set_fields(f); load = 1'b1;
    tick();
    load = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      bad++; $display("FAIL unknown_pulse: got err=%b valid=%b want 1/0", err, valid);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || valid !== 1'b0 || ready !== 1'b1 || sent_count !== exp_count[15:0]) begin
      bad++;
      $display("FAIL unknown_after: got err=%b valid=%b ready=%b count=%0d want 0/0/1/%0d",
               err, valid, ready, sent_count, exp_count);
    end
  endtask

  task automatic test_reset_mid;
    itch_fields_t f;
    int n;
    tick();
    f = rand_fields(MSG_A);
    build_frame(f);
    set_fields(f); load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || message !== frame_q[i]) begin
        bad++; $display("FAIL rst_mid_pre byte %0d: got v=%b m=%h want 1/%h", i, valid, message, frame_q[i]);
      end
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({valid, message, end_msg} !== 10'h000 || sent_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_abort: got v=%b m=%h e=%b count=%0d want 0/00/0/0",
               valid, message, end_msg, sent_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_count = 0;
    tick();
    f = rand_fields(MSG_X);
    build_frame(f);
    n = frame_q.size();
    set_fields(f); load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if ({valid, message, start_msg, end_msg} !== {1'b1, frame_q[i], i == 0, i == n - 1}) begin
        bad++;
        $display("FAIL rst_mid_x byte %0d: got v=%b m=%h s=%b e=%b want v=1 m=%h s=%b e=%b",
                 i, valid, message, start_msg, end_msg, frame_q[i], i == 0, i == n - 1);
      end
    end
    @(negedge clk);
    exp_count = 1;
    total++;
    if (valid !== 1'b0 || sent_count !== 16'd1) begin
      bad++; $display("FAIL rst_mid_x_after: got valid=%b count=%0d want 0/1", valid, sent_count);
    end
  endtask

  // Reference: a message accepted at cycle t starts at max(t+1, line free)
  // and occupies consecutive cycles; ready is low strictly between the
  // acceptance of a waiting message and its start.
  task automatic test_random;
    int acc_q[$], st_q[$], end_q[$];
    itch_fields_t exp_f_q[$];
    itch_fields_t f, d, e;
    int line_free, base, st, nsent, r;
    bit rdy, ld, known;
    logic [7:0] tp, eb;
    logic [31:0] rr;
    for (int k = 0; k < NC + 100; k++) begin
      exp_b[k] = -1; exp_s[k] = 0; exp_e[k] = 0; exp_err[k] = 0;
    end
    line_free = 0;
    base = exp_count;
    tick();
    for (int t = 0; t < NC; t++) begin
      rdy = 1'b1;
      foreach (acc_q[k]) if (acc_q[k] < t && t < st_q[k]) rdy = 1'b0;
      ld = (t < NC - 100) && ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      rr = $urandom;
      tp = (r < 2) ? 8'h41 : (r < 4) ? 8'h45 : (r < 6) ? 8'h58 : (r < 8) ? 8'h44 :
           (r == 8) ? 8'h5A : rr[7:0];
      known = (tp == 8'h41 || tp == 8'h45 || tp == 8'h58 || tp == 8'h44);
      f = rand_fields(tp);
      set_fields(f);
      load = ld;
      if (ld && rdy) begin
        if (known) begin
          build_frame(f);
          st = (line_free > t + 1) ? line_free : t + 1;
          foreach (frame_q[k]) exp_b[st + k] = {24'd0, frame_q[k]};
          exp_s[st] = 1'b1;
          exp_e[st + frame_q.size() - 1] = 1'b1;
          line_free = st + frame_q.size();
          acc_q.push_back(t); st_q.push_back(st);
          end_q.push_back(st + frame_q.size() - 1);
          exp_f_q.push_back(f);
        end else begin
          exp_err[t + 1] = 1'b1;
        end
      end
      @(negedge clk);
      eb = (exp_b[t] >= 0) ? exp_b[t][7:0] : 8'h00;
      total++;
      if ({valid, message, start_msg, end_msg} !== {exp_b[t] >= 0, eb, exp_s[t], exp_e[t]}) begin
        bad++;
        $display("FAIL random stream cycle %0d: got v=%b m=%h s=%b e=%b want v=%b m=%h s=%b e=%b",
                 t, valid, message, start_msg, end_msg, exp_b[t] >= 0, eb, exp_s[t], exp_e[t]);
      end
      total++;
      if (ready !== rdy || err !== exp_err[t]) begin
        bad++;
        $display("FAIL random ready/err cycle %0d: got ready=%b err=%b want %b/%b",
                 t, ready, err, rdy, exp_err[t]);
      end
      nsent = base;
      foreach (end_q[k]) if (end_q[k] < t) nsent++;
      total++;
      if (sent_count !== nsent[15:0]) begin
        bad++; $display("FAIL random count cycle %0d: got %0d want %0d", t, sent_count, nsent[15:0]);
      end
      if (valid === 1'b1) begin
        if (start_msg === 1'b1) rx_q.delete();
        rx_q.push_back(message);
        if (end_msg === 1'b1) begin
          parse_rx(d);
          total++;
          if (exp_f_q.size() == 0) begin
            bad++; $display("FAIL loopback cycle %0d: frame received with none expected", t);
          end else begin
            e = carried(exp_f_q.pop_front());
            if (d !== e || rx_pos != rx_q.size()) begin
              bad++;
              $display("FAIL loopback cycle %0d: got len=%0d fields=%h want len=%0d fields=%h",
                       t, rx_q.size(), d, rx_pos, e);
            end
          end
        end
      end
      tick();
    end
    load = 1'b0;
    total++;
    if (exp_f_q.size() != 0) begin
      bad++; $display("FAIL random drain: got %0d frames missing want 0", exp_f_q.size());
    end
    exp_count = base + end_q.size();
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    test_reset();
    test_single_d();
    test_back_to_back();
    test_load_on_end();
    test_unknown();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_serializer.md
ITCH_SERIALIZER -- requirements
Module: itch_serializer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port load, input, 1, request to transmit the field set; accepted when load && ready.
REQ-004 SHALL have port ready, output, 1, high when the pending buffer is empty.
REQ-005 SHALL have port in_msg_type, input, 8, message type: 'A'=8'h41, 'E'=8'h45, 'X'=8'h58, 'D'=8'h44.
REQ-006 SHALL have field input ports: in_stock_locate[15:0], in_tracking_no[15:0], in_timestamp[47:0], in_order_ref_no[63:0], in_shares[31:0], in_buy_sell[7:0], in_stock[63:0], in_price[31:0], in_match_no[63:0].
REQ-007 SHALL have port message, output, 8, serial byte.
REQ-008 SHALL have port valid, output, 1, message byte valid.
REQ-009 SHALL have port start_msg, output, 1, first byte (type) of a message.
REQ-010 SHALL have port end_msg, output, 1, last byte of a message.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on an accepted unknown type.
REQ-012 SHALL have port sent_count, output, 16, count of completed messages; wraps 16'hFFFF->0.

Function
REQ-013 SHALL emit bytes big-endian at byte index i: 0 type; 1-2 locate; 3-4 tracking; 5-10 timestamp; 11-18 order_ref.
REQ-014 SHALL emit 19 bytes total (indices 0-18) for D.
REQ-015 SHALL emit 23 bytes total for X, with 19-22 shares.
REQ-016 SHALL emit 31 bytes total for E, with 19-22 shares and 23-30 match_no.
REQ-017 SHALL emit 36 bytes total for A, with 19 buy_sell, 20-23 shares, 24-31 stock, 32-35 price.
REQ-018 SHALL keep valid high on every cycle of a message, with no gaps, since a gap invalidates the message at the receiver.
REQ-019 SHALL assert start_msg only at index 0 and end_msg only at index len-1; both SHALL be qualified by valid.
REQ-020 SHALL drive message=0 when valid is low.
REQ-021 SHALL use an FSM with states IDLE and SEND, and a byte counter byte_idx[5:0].
REQ-022 SHALL, in IDLE, when a load is accepted in cycle N with a known type, capture the fields into the active register and emit index 0 in cycle N+1.
REQ-023 SHALL, in SEND, capture an accepted load into the pending register and deassert ready the next cycle.
REQ-024 SHALL, in the end_msg cycle: if pending is full, promote it to active, emit index 0 next cycle, and free pending; else if load && ready in the same cycle, use that load directly as active and emit index 0 next cycle; else go to IDLE.
REQ-025 SHALL sustain back-to-back messages with zero idle cycles.
REQ-026 SHALL discard a load with an unknown type: accepted (ready semantics unchanged), no bytes emitted, err pulsed in cycle N+1, state unaffected.
REQ-027 SHALL increment sent_count in the cycle after end_msg.
REQ-028 SHALL ignore load while ready is low; no field change.

Reset
REQ-029 SHALL on rst force: state=IDLE, byte_idx=0, active and pending registers cleared, pending empty, message=0, valid=0, start_msg=0, end_msg=0, err=0, sent_count=0; ready=1 after release.
REQ-030 SHALL on rst mid-message abandon the message immediately; no end_msg emitted; the partial message is not counted.

Structure
REQ-031 SHALL place in a shared package itch_pkg: type constants MSG_A/E/X/D, length constants LEN_A=36, LEN_E=31, LEN_X=23, LEN_D=19, and a packed struct itch_fields_t of all fields, which the parser reuses.
REQ-032 SHALL implement as a single module with no sub-module; byte selection is a combinational case on {type, byte_idx}.

Verification
REQ-033 SHALL verify single D: load D, locate=16'h0102, order_ref=64'h1122334455667788 -> 19 valid bytes 44,01,02,...,88; start_msg on byte 0; end_msg on byte 18.
REQ-034 SHALL verify A then E back-to-back: second load during A -> ready low; A's end_msg cycle followed immediately by E start_msg; 67 consecutive valid cycles.
REQ-035 SHALL verify load during end_msg cycle with pending empty -> next message starts the next cycle; no gap.
REQ-036 SHALL verify unknown type 8'h5A -> err pulse one cycle after accept, valid stays 0, sent_count unchanged.
REQ-037 SHALL verify rst asserted at byte 10 of an A -> valid 0 immediately, sent_count 0, and a fresh X after release serializes correctly (23 bytes).
REQ-038 SHALL verify loopback into the parser for all four types -> valid_msg pulse with decoded fields equal to the inputs.
